// File: rtl/note_pkg.sv
// Shared types and helpers for the note chart scroller.
package note_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, RUN, DRAIN, DONE} state_t;

  // Flat window index: row 0 (judgement row) occupies the lowest LANES bits.
  function automatic int win_bit(input int row, input int lane, input int lanes);
    return row * lanes + lane;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_v}) ? max_v : sum[31:0];
  endfunction

endpackage

// File: rtl/note_chart_scroller_tempo.sv
// Tempo divider: substep events every tick_period+1 enabled clocks, row advance every SUBSTEPS substeps.
module note_tempo_tick #(
  parameter int SUBSTEPS = 7,
  parameter int TICK_W   = 17,
  parameter int OFF_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [TICK_W-1:0] tick_period,
  output logic [OFF_W-1:0]  offset,
  output logic              row_adv
);

  logic [TICK_W-1:0] tick_cnt;
  logic              substep;

  assign substep = enable && (tick_cnt == tick_period);
  assign row_adv = substep && (offset == OFF_W'(SUBSTEPS - 1));

  // Disabled (paused) cycles hold both counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      offset   <= '0;
    end else if (clear) begin
      tick_cnt <= '0;
      offset   <= '0;
    end else if (enable) begin
      if (substep) begin
        tick_cnt <= '0;
        offset   <= row_adv ? '0 : offset + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_chart_scroller.sv
// Rhythm-game note engine: streams chart rows into a scrolling window and judges hits at row 0.
module note_chart_scroller
  import note_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int DEPTH    = 10,
  parameter int SUBSTEPS = 7,
  parameter int ADDR_W   = 11,
  parameter int TICK_W   = 17,
  parameter int COMBO_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       ack,
  input  logic [TICK_W-1:0]          tick_period,
  input  logic [ADDR_W-1:0]          chart_len,
  output logic                       rom_rd,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [LANES-1:0]           rom_data,
  input  logic [LANES-1:0]           hit,
  output logic [LANES*DEPTH-1:0]     window,
  output logic [$clog2(SUBSTEPS)-1:0] offset,
  output logic [LANES-1:0]           hit_ok,
  output logic [LANES-1:0]           miss,
  output logic [COMBO_W-1:0]         combo,
  output logic [COMBO_W-1:0]         max_combo,
  output logic                       busy,
  output logic                       finish,
  output logic [2:0]                 fsm_state
);

  localparam int          OFF_W     = $clog2(SUBSTEPS);
  localparam int          WIN_W     = LANES * DEPTH;
  localparam int          DR_W      = $clog2(DEPTH + 1);
  localparam logic [31:0] COMBO_MAX = 32'((1 << COMBO_W) - 1);

  state_t              state;
  logic [TICK_W-1:0]   period_q;
  logic [ADDR_W-1:0]   len_q;
  logic [ADDR_W-1:0]   row_idx;
  logic [DR_W-1:0]     drain_cnt;
  logic [LANES-1:0]    row_buf;
  logic                rd_pend;
  logic                judge_en;
  logic                row_adv;
  logic [ADDR_W:0]     next_idx;
  logic                last_row;
  logic [LANES-1:0]    row0;
  logic [LANES-1:0]    hit_v;
  logic [LANES-1:0]    miss_v;
  logic [COMBO_W-1:0]  combo_next;
  int                  hits_n;

  assign judge_en  = ((state == RUN) || (state == DRAIN)) && !pause;
  assign busy      = (state == FETCH) || (state == RUN) || (state == DRAIN);
  assign finish    = (state == DONE);
  assign fsm_state = state;
  assign next_idx  = {1'b0, row_idx} + 1'b1;
  assign last_row  = (next_idx == {1'b0, len_q});

  note_tempo_tick #(.SUBSTEPS(SUBSTEPS), .TICK_W(TICK_W), .OFF_W(OFF_W)) u_tempo (
    .clk         (clk),
    .rst         (rst),
    .clear       (!((state == RUN) || (state == DRAIN))),
    .enable      (judge_en),
    .tick_period (period_q),
    .offset      (offset),
    .row_adv     (row_adv)
  );

  // A hit landing on the advance cycle is judged before the row leaves, so it never also misses.
  always_comb begin
    row0 = '0;
    for (int l = 0; l < LANES; l++) row0[l] = window[win_bit(0, l, LANES)];
    hit_v  = judge_en ? (hit & row0) : '0;
    miss_v = row_adv ? (row0 & ~hit_v) : '0;
    hits_n = 0;
    for (int l = 0; l < LANES; l++) hits_n = hits_n + (hit_v[l] ? 1 : 0);
    combo_next = (|miss_v) ? '0 : COMBO_W'(sat_add(32'(combo), 32'(hits_n), COMBO_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      period_q  <= '0;
      len_q     <= '0;
      row_idx   <= '0;
      drain_cnt <= '0;
      row_buf   <= '0;
      rd_pend   <= 1'b0;
      rom_rd    <= 1'b0;
      rom_addr  <= '0;
      window    <= '0;
      hit_ok    <= '0;
      miss      <= '0;
      combo     <= '0;
      max_combo <= '0;
    end else begin
      rom_rd  <= 1'b0;
      rd_pend <= rom_rd;
      hit_ok  <= hit_v;
      miss    <= miss_v;
      // Read data arrives the cycle after the strobe.
      if (rd_pend) row_buf <= rom_data;
      case (state)
        IDLE: if (start) begin
          combo     <= '0;
          max_combo <= '0;
          period_q  <= tick_period;
          len_q     <= chart_len;
          row_idx   <= '0;
          drain_cnt <= '0;
          window    <= '0;
          if (chart_len == '0) begin
            state <= DONE;
          end else begin
            state    <= FETCH;
            rom_rd   <= 1'b1;
            rom_addr <= '0;
          end
        end
        FETCH: if (rd_pend) state <= RUN;
        RUN, DRAIN: begin
          combo     <= combo_next;
          max_combo <= (combo_next > max_combo) ? combo_next : max_combo;
          if (row_adv) begin
            window <= {row_buf, window[WIN_W-1:LANES]};
            if (state == RUN) begin
              row_idx <= next_idx[ADDR_W-1:0];
              if (last_row) begin
                row_buf <= '0;
                state   <= DRAIN;
              end else begin
                rom_rd   <= 1'b1;
                rom_addr <= next_idx[ADDR_W-1:0];
              end
            end else if (drain_cnt == DR_W'(DEPTH - 1)) begin
              window <= '0;
              state  <= DONE;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end else begin
            window <= window & ~WIN_W'(hit_v);
          end
        end
        DONE: if (ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/note_chart_scroller.md
Name: note_chart_scroller

Overview:
Parametrised rhythm-game note engine. Streams a note chart row-by-row from an external chart ROM and scrolls it through a DEPTH-row visible window with sub-row pixel offsets. Judges per-lane player hits at the judgement row and keeps combo and max-combo scores. Sits between the chart ROM/song selector and the LED-matrix renderer. Generalises the fixed two-colour, ten-row shifter to N lanes, runtime tempo and chart length, pause, and explicit miss reporting.

Parameters:
LANES, 2, number of note lanes (colours)
DEPTH, 10, visible window rows
SUBSTEPS, 7, pixel offsets per row advance (>=2)
ADDR_W, 11, chart ROM address width
TICK_W, 17, tempo divider width
COMBO_W, 8, combo counter width

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  pulse; begin song (IDLE only)
pause  in  1  level; freezes scroll and judgement
ack  in  1  pulse; leave DONE
tick_period  in  TICK_W  clocks per substep minus 1 (>=2); sampled on start
chart_len  in  ADDR_W  chart rows; sampled on start
rom_rd  out  1  chart read strobe
rom_addr  out  ADDR_W  chart row address
rom_data  in  LANES  row bitmap; valid exactly 1 cycle after rom_rd
hit  in  LANES  per-lane press pulses
window  out  LANES*DEPTH  bit r*LANES+l = row r, lane l; row 0 = judgement row
offset  out  $clog2(SUBSTEPS)  current substep
hit_ok  out  LANES  1-cycle pulse per judged hit
miss  out  LANES  1-cycle pulse per missed note
combo  out  COMBO_W  current combo
max_combo  out  COMBO_W  best combo this song
busy  out  1  high outside IDLE/DONE
finish  out  1  high in DONE

Behaviour:
- Reset: asynchronous, active-high; clock clk. Every output is 0 after reset; FSM goes to IDLE; all counters and window are cleared. Reset mid-song aborts with no finish pulse.
- FSM: IDLE -> FETCH on start (chart_len!=0); IDLE -> DONE on start with chart_len==0. FETCH -> RUN after 2 cycles: rom_rd=1, addr=0, then capture into the 1-entry prefetch buffer. RUN -> DRAIN when the last chart row enters the window. DRAIN -> DONE after DEPTH further row advances. DONE -> IDLE on ack.
- start is ignored outside IDLE. ack is ignored outside DONE.
- Tick: in RUN/DRAIN with pause=0, tick_cnt counts 0..tick_period. Wrap = substep event. Pause holds tick_cnt and offset.
- Substep event: offset++. When offset==SUBSTEPS-1, offset wraps to 0 and a row advance occurs.
- Row advance:
  - Window shifts toward row 0; the prefetch buffer enters row DEPTH-1; row_idx++.
  - If row_idx<chart_len: rom_rd pulses with rom_addr=row_idx. Otherwise the buffer loads 0.
  - Each lane bit still set in the outgoing row 0 pulses miss for that lane.
- Hit: in RUN/DRAIN with pause=0, hit[l] with row 0 lane l set clears that bit and pulses hit_ok[l]. Hit on an empty lane is ignored (no penalty).
- Hit on the same cycle as a row advance is judged against the outgoing row 0: counts as hit_ok, not miss.
- Combo: combo_next = (|miss) ? 0 : sat(combo + popcount(hit_ok)). Saturates at 2^COMBO_W-1.
- max_combo = max(max_combo, combo_next). Both are cleared on start; both are held in DONE.
- window and offset clear on entry to DONE.

Decomposition:
- Package note_pkg: FSM state enum {IDLE,FETCH,RUN,DRAIN,DONE}, the window bit-index function, and the saturating-add function.
- One sub-module, note_tempo_tick: tick counter plus substep/row-advance generation with pause.

Test Plan:
LANES=2, DEPTH=4, SUBSTEPS=2, tick_period=2 (substep every 3 clks, row every 6 clks).
1. Reset mid-RUN with window!=0 -> all outputs 0 next cycle; state IDLE; no finish.
2. chart_len=3, ROM {01,10,11}, no hits -> rom_addr 0,1,2 read once each. Each note reaches row 0 and produces miss; miss = 01, 10, 11 over successive row advances. combo stays 0. finish rises after 3+4 row advances.
3. Same chart, hit on each note while it is at row 0 -> hit_ok 01, 10, 11. combo ends at 4, max_combo=4, no miss.
4. Hit lane 0 exactly on the row-advance cycle of note 01 -> hit_ok[0]=1, miss=0, combo=1.
5. pause held 20 clks mid-RUN -> offset, window and tick_cnt frozen. Resumed timing is shifted by exactly 20 clks.
6. COMBO_W=2, 5 consecutive hits -> combo saturates at 3. One miss -> combo 0, max_combo stays 3.
